// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: shared definitions for the ALU issue/writeback controller.
// Instruction field positions, type/function codes, FSM state encoding,
// condition-code bit indices and small decode helpers.
package alu_issue_pkg;

    // Instruction field bit ranges
    localparam int OPC_LSB  = 0;
    localparam int TYPE_MSB = 2;
    localparam int FN_LSB   = 3;
    localparam int RD_LSB   = 7;
    localparam int RS1_LSB  = 12;
    localparam int RS2_LSB  = 17;

    // Instruction type codes (opcode[2:0])
    localparam logic [2:0] TYPE_R = 3'd1;
    localparam logic [2:0] TYPE_I = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;

    // Function codes (opcode[6:3])
    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_MULT = 4'd2;
    localparam logic [3:0] FN_BEQ  = 4'd0;
    localparam logic [3:0] FN_BNE  = 4'd1;

    // ALU condition-code bit indices
    localparam int CC_BR  = 0;
    localparam int CC_OVF = 1;
    localparam int CC_UDF = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;

    function automatic logic [31:0] sext15(input logic [14:0] v);
        return {{17{v[14]}}, v};
    endfunction

    function automatic logic is_legal_type(input logic [2:0] t);
        return (t == TYPE_R) || (t == TYPE_I) || (t == TYPE_B);
    endfunction

    function automatic logic writes_rd(input logic [2:0] t);
        return (t == TYPE_R) || (t == TYPE_I);
    endfunction

endpackage

// File: rtl/alu_issue_regfile32.sv
// regfile32: 32 x 32-bit register file.
// Ports: clk/rst_n (async active-low clears every register), two
// combinational read ports (raddr1/rdata1, raddr2/rdata2), a combinational
// debug read port (dbg_raddr/dbg_rdata) and one synchronous write port
// (we/waddr/wdata). Register x0 always reads 0 and ignores writes.
module regfile32
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  raddr1,
    output logic [31:0] rdata1,
    input  logic [4:0]  raddr2,
    output logic [31:0] rdata2,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];

    // Next-state of the array: single write port, x0 write suppressed
    always_comb begin
        regs_d = regs_q;
        if (we && (waddr != 5'd0)) begin
            regs_d[waddr] = wdata;
        end else begin
            regs_d[0] = 32'd0;
        end
    end

    // Register array storage with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    assign rdata1    = (raddr1 == 5'd0)    ? 32'd0 : regs_q[raddr1];
    assign rdata2    = (raddr2 == 5'd0)    ? 32'd0 : regs_q[raddr2];
    assign dbg_rdata = (dbg_raddr == 5'd0) ? 32'd0 : regs_q[dbg_raddr];

endmodule

// File: rtl/alu_issue.sv
// alu_issue: issue/writeback controller in front of the shared ALU.
// Ports: clk, rst_n (async active-low); inst_valid/inst_ready/inst/inst_pc
// instruction handshake; alu_a/alu_b/alu_opcode registered ALU operands;
// alu_out/alu_cc combinational ALU result and flags; retire_valid,
// redirect_valid/redirect_pc, illegal one-cycle pulses; status_ovf/udf
// sticky flags with status_clr; dbg_raddr/dbg_rdata register peek.
// Sequence per instruction: IDLE (accept) -> EXEC (ALU) -> WB (write/pulse).
module alu_issue
    import alu_issue_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inst_valid,
    output logic        inst_ready,
    input  logic [31:0] inst,
    input  logic [31:0] inst_pc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [6:0]  alu_opcode,
    input  logic [31:0] alu_out,
    input  logic [3:0]  alu_cc,
    output logic        retire_valid,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        illegal,
    output logic        status_ovf,
    output logic        status_udf,
    input  logic        status_clr,
    input  logic [4:0]  dbg_raddr,
    output logic [31:0] dbg_rdata
);

    state_e      state_q, state_d;
    logic [31:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [6:0]  alu_opcode_q, alu_opcode_d;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  type_q, type_d;
    logic [31:0] target_q, target_d;
    logic [31:0] res_q, res_d;
    logic        cc_ovf_q, cc_ovf_d, cc_udf_q, cc_udf_d;
    logic        retire_q, retire_d, redirect_q, redirect_d, illegal_q, illegal_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        ovf_q, ovf_d, udf_q, udf_d;

    logic [2:0]  inst_type_s;
    logic [31:0] rs1_data_s, rs2_data_s, offset_s;
    logic        rf_we_s, set_ovf_s, set_udf_s;
    logic        unused_cc_s;

    assign inst_type_s = inst[TYPE_MSB:OPC_LSB];
    // Branch offset is split around the rd field; scaled to bytes below
    assign offset_s    = sext15({inst[31:22], inst[RD_LSB +: 5]});
    assign unused_cc_s = alu_cc[3];

    regfile32 u_regfile (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr1    (inst[RS1_LSB +: 5]),
        .rdata1    (rs1_data_s),
        .raddr2    (inst[RS2_LSB +: 5]),
        .rdata2    (rs2_data_s),
        .dbg_raddr (dbg_raddr),
        .dbg_rdata (dbg_rdata),
        .we        (rf_we_s),
        .waddr     (rd_q),
        .wdata     (res_q)
    );

    // FSM next-state, operand capture, pulses and sticky status
    always_comb begin
        state_d       = state_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_opcode_d  = alu_opcode_q;
        rd_d          = rd_q;
        type_d        = type_q;
        target_d      = target_q;
        res_d         = res_q;
        cc_ovf_d      = cc_ovf_q;
        cc_udf_d      = cc_udf_q;
        redirect_pc_d = redirect_pc_q;
        retire_d      = 1'b0;
        redirect_d    = 1'b0;
        illegal_d     = 1'b0;
        rf_we_s       = 1'b0;
        set_ovf_s     = 1'b0;
        set_udf_s     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (inst_valid) begin
                    type_d = inst_type_s;
                    if (is_legal_type(inst_type_s)) begin
                        alu_a_d      = rs1_data_s;
                        alu_b_d      = (inst_type_s == TYPE_I) ? sext15(inst[31:17]) : rs2_data_s;
                        alu_opcode_d = inst[6:0];
                        rd_d         = inst[RD_LSB +: 5];
                        target_d     = inst_pc + {offset_s[29:0], 2'b00};
                        state_d      = ST_EXEC;
                    end else begin
                        // Illegal words skip the ALU; the pulse lines up with WB
                        illegal_d = 1'b1;
                        state_d   = ST_WB;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                res_d      = alu_out;
                cc_ovf_d   = alu_cc[CC_OVF];
                cc_udf_d   = alu_cc[CC_UDF];
                retire_d   = 1'b1;
                redirect_d = (type_q == TYPE_B) && alu_cc[CC_BR];
                if (redirect_d) begin
                    redirect_pc_d = target_q;
                end else begin
                    redirect_pc_d = redirect_pc_q;
                end
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we_s   = writes_rd(type_q);
                set_ovf_s = writes_rd(type_q) && cc_ovf_q;
                set_udf_s = writes_rd(type_q) && cc_udf_q;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Set takes priority over a simultaneous clear
        ovf_d = (ovf_q & ~status_clr) | set_ovf_s;
        udf_d = (udf_q & ~status_clr) | set_udf_s;
    end

    // State, operand and status registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            alu_opcode_q  <= 7'd0;
            rd_q          <= 5'd0;
            type_q        <= 3'd0;
            target_q      <= 32'd0;
            res_q         <= 32'd0;
            cc_ovf_q      <= 1'b0;
            cc_udf_q      <= 1'b0;
            retire_q      <= 1'b0;
            redirect_q    <= 1'b0;
            illegal_q     <= 1'b0;
            redirect_pc_q <= 32'd0;
            ovf_q         <= 1'b0;
            udf_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_opcode_q  <= alu_opcode_d;
            rd_q          <= rd_d;
            type_q        <= type_d;
            target_q      <= target_d;
            res_q         <= res_d;
            cc_ovf_q      <= cc_ovf_d;
            cc_udf_q      <= cc_udf_d;
            retire_q      <= retire_d;
            redirect_q    <= redirect_d;
            illegal_q     <= illegal_d;
            redirect_pc_q <= redirect_pc_d;
            ovf_q         <= ovf_d;
            udf_q         <= udf_d;
        end
    end

    assign inst_ready     = (state_q == ST_IDLE);
    assign alu_a          = alu_a_q;
    assign alu_b          = alu_b_q;
    assign alu_opcode     = alu_opcode_q;
    assign retire_valid   = retire_q;
    assign redirect_valid = redirect_q;
    assign redirect_pc    = redirect_pc_q;
    assign illegal        = illegal_q;
    assign status_ovf     = ovf_q;
    assign status_udf     = udf_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a small behavioural ALU attached.
module tb_alu_issue;
    import alu_issue_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inst_valid = 1'b0;
    logic        inst_ready;
    logic [31:0] inst = 32'd0;
    logic [31:0] inst_pc = 32'd0;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [6:0]  alu_opcode;
    logic [3:0]  alu_cc;
    logic        retire_valid, redirect_valid, illegal, status_ovf, status_udf;
    logic [31:0] redirect_pc, dbg_rdata;
    logic        status_clr = 1'b0;
    logic [4:0]  dbg_raddr = 5'd0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_issue dut (
        .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
        .inst(inst), .inst_pc(inst_pc), .alu_a(alu_a), .alu_b(alu_b),
        .alu_opcode(alu_opcode), .alu_out(alu_out), .alu_cc(alu_cc),
        .retire_valid(retire_valid), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .illegal(illegal), .status_ovf(status_ovf),
        .status_udf(status_udf), .status_clr(status_clr), .dbg_raddr(dbg_raddr),
        .dbg_rdata(dbg_rdata)
    );

    // Behavioural ALU: ADD flags signed overflow, SUB flags unsigned borrow,
    // MULT flags a product wider than 32 bits, branches compare a and b.
    logic [63:0] prod_s;
    always_comb begin
        alu_out = 32'd0;
        alu_cc  = 4'd0;
        prod_s  = {32'd0, alu_a} * {32'd0, alu_b};
        case (alu_opcode[2:0])
            3'd1, 3'd2: begin
                case (alu_opcode[6:3])
                    4'd0: begin
                        alu_out   = alu_a + alu_b;
                        alu_cc[1] = (alu_a[31] == alu_b[31]) && (alu_out[31] != alu_a[31]);
                    end
                    4'd1: begin
                        alu_out   = alu_a - alu_b;
                        alu_cc[2] = (alu_a < alu_b);
                    end
                    4'd2: begin
                        alu_out   = prod_s[31:0];
                        alu_cc[1] = |prod_s[63:32];
                    end
                    default: alu_out = 32'd0;
                endcase
            end
            3'd3: alu_cc[0] = (alu_opcode[6:3] == 4'd0) ? (alu_a == alu_b) : (alu_a != alu_b);
            default: alu_out = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [3:0] fn, input logic [4:0] rd, rs1, rs2);
        return {10'd0, rs2, rs1, rd, fn, 3'd1};
    endfunction

    function automatic logic [31:0] enc_i(input logic [3:0] fn, input logic [4:0] rd, rs1,
                                          input logic [14:0] imm);
        return {imm, rs1, rd, fn, 3'd2};
    endfunction

    function automatic logic [31:0] enc_b(input logic [3:0] fn, input logic [4:0] rs1, rs2,
                                          input logic [14:0] off);
        return {off[14:5], rs2, rs1, off[4:0], fn, 3'd3};
    endfunction

    task automatic peek(input string tag, input logic [4:0] r, input logic [31:0] exp);
        dbg_raddr = r;
        #1;
        chk(tag, dbg_rdata, exp);
    endtask

    // One legal instruction: handshake at T, operands at T+1, retire at T+2,
    // ready again at T+3.
    task automatic issue(input string tag, input logic [31:0] w, input logic [31:0] pc,
                         input logic [31:0] ea, input logic [31:0] eb, input logic eredir);
        @(negedge clk);
        chk({tag, ".ready_T"}, {31'd0, inst_ready}, 32'd1);
        inst = w; inst_pc = pc; inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0; inst = 32'hFFFF_FFFF; inst_pc = 32'hFFFF_FFFF;
        chk({tag, ".ready_T1"}, {31'd0, inst_ready}, 32'd0);
        chk({tag, ".alu_a"}, alu_a, ea);
        chk({tag, ".alu_b"}, alu_b, eb);
        chk({tag, ".alu_opc"}, {25'd0, alu_opcode}, {25'd0, w[6:0]});
        chk({tag, ".retire_T1"}, {31'd0, retire_valid}, 32'd0);
        @(negedge clk);
        chk({tag, ".ready_T2"}, {31'd0, inst_ready}, 32'd0);
        chk({tag, ".retire_T2"}, {31'd0, retire_valid}, 32'd1);
        chk({tag, ".redirect_T2"}, {31'd0, redirect_valid}, {31'd0, eredir});
        @(negedge clk);
        chk({tag, ".ready_T3"}, {31'd0, inst_ready}, 32'd1);
        chk({tag, ".retire_T3"}, {31'd0, retire_valid}, 32'd0);
        chk({tag, ".redirect_T3"}, {31'd0, redirect_valid}, 32'd0);
        chk({tag, ".alu_a_hold"}, alu_a, ea);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset
        repeat (3) @(negedge clk);
        chk("rst.alu_a", alu_a, 32'd0);
        chk("rst.alu_b", alu_b, 32'd0);
        chk("rst.alu_opc", {25'd0, alu_opcode}, 32'd0);
        chk("rst.pulses", {29'd0, retire_valid, redirect_valid, illegal}, 32'd0);
        chk("rst.redirect_pc", redirect_pc, 32'd0);
        chk("rst.status", {30'd0, status_ovf, status_udf}, 32'd0);
        peek("rst.x5", 5'd5, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst.ready", {31'd0, inst_ready}, 32'd1);

        // Basic arithmetic
        issue("addi_x1", enc_i(FN_ADD, 5'd1, 5'd0, 15'd5), 32'd0, 32'd0, 32'd5, 1'b0);
        peek("x1", 5'd1, 32'd5);
        issue("add_x2", enc_r(FN_ADD, 5'd2, 5'd1, 5'd1), 32'd0, 32'd5, 32'd5, 1'b0);
        peek("x2", 5'd2, 32'd10);

        // Underflow
        issue("subi_x3", enc_i(FN_SUB, 5'd3, 5'd0, 15'd1), 32'd0, 32'd0, 32'd1, 1'b0);
        peek("x3", 5'd3, 32'hFFFF_FFFF);
        chk("udf_set", {30'd0, status_ovf, status_udf}, 32'd1);

        // Negative immediate sign extension
        issue("addi_neg", enc_i(FN_ADD, 5'd9, 5'd0, 15'h7FFE), 32'd0, 32'd0, 32'hFFFF_FFFE, 1'b0);
        peek("x9", 5'd9, 32'hFFFF_FFFE);

        // Build 0x40000000, then overflow
        issue("addi_x4", enc_i(FN_ADD, 5'd4, 5'd0, 15'h1000), 32'd0, 32'd0, 32'h1000, 1'b0);
        issue("muli_x5a", enc_i(FN_MULT, 5'd5, 5'd4, 15'h2000), 32'd0, 32'h1000, 32'h2000, 1'b0);
        issue("muli_x5b", enc_i(FN_MULT, 5'd5, 5'd5, 15'd32), 32'd0, 32'h0200_0000, 32'd32, 1'b0);
        peek("x5", 5'd5, 32'h4000_0000);
        issue("add_x6", enc_r(FN_ADD, 5'd6, 5'd5, 5'd5), 32'd0, 32'h4000_0000, 32'h4000_0000, 1'b0);
        peek("x6", 5'd6, 32'h8000_0000);
        chk("ovf_set", {30'd0, status_ovf, status_udf}, 32'd3);
        status_clr = 1'b1;
        @(negedge clk);
        status_clr = 1'b0;
        chk("status_clr", {30'd0, status_ovf, status_udf}, 32'd0);

        // Set wins over a clear held through writeback
        status_clr = 1'b1;
        issue("add_x8", enc_r(FN_ADD, 5'd8, 5'd5, 5'd5), 32'd0, 32'h4000_0000, 32'h4000_0000, 1'b0);
        chk("set_wins", {30'd0, status_ovf, status_udf}, 32'd2);
        @(negedge clk);
        status_clr = 1'b0;
        chk("clr_again", {30'd0, status_ovf, status_udf}, 32'd0);

        // Branches (rd field of BEQ carries offset bits = 4, x4 must not change)
        issue("beq", enc_b(FN_BEQ, 5'd1, 5'd1, 15'd4), 32'h100, 32'd5, 32'd5, 1'b1);
        chk("beq.target", redirect_pc, 32'h110);
        peek("beq.x4", 5'd4, 32'h1000);
        issue("bne", enc_b(FN_BNE, 5'd1, 5'd1, 15'd4), 32'h200, 32'd5, 32'd5, 1'b0);
        issue("beq_back", enc_b(FN_BEQ, 5'd2, 5'd2, 15'h7FFF), 32'h200, 32'd10, 32'd10, 1'b1);
        chk("beq_back.target", redirect_pc, 32'h1FC);

        // x0 stays zero
        issue("addi_x0", enc_i(FN_ADD, 5'd0, 5'd0, 15'd7), 32'd0, 32'd0, 32'd7, 1'b0);
        peek("x0", 5'd0, 32'd0);

        // Illegal type 7 with rd=x1
        @(negedge clk);
        inst = {10'd0, 5'd0, 5'd0, 5'd1, 4'd0, 3'd7}; inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        chk("ill.pulse", {31'd0, illegal}, 32'd1);
        chk("ill.retire", {31'd0, retire_valid}, 32'd0);
        chk("ill.ready", {31'd0, inst_ready}, 32'd0);
        @(negedge clk);
        chk("ill.pulse_end", {31'd0, illegal}, 32'd0);
        chk("ill.ready_back", {31'd0, inst_ready}, 32'd1);
        peek("ill.x1", 5'd1, 32'd5);

        // Reset during EXEC of ADD x7
        @(negedge clk);
        inst = enc_i(FN_ADD, 5'd7, 5'd0, 15'd9); inst_valid = 1'b1;
        @(negedge clk);
        inst_valid = 1'b0;
        chk("rx.alu_b", alu_b, 32'd9);
        rst_n = 1'b0;
        #1;
        chk("rx.ready", {31'd0, inst_ready}, 32'd1);
        chk("rx.alu_b_clr", alu_b, 32'd0);
        @(negedge clk);
        chk("rx.retire", {31'd0, retire_valid}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rx.retire_after", {31'd0, retire_valid}, 32'd0);
        peek("rx.x7", 5'd7, 32'd0);
        peek("rx.x1", 5'd1, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
